logic_reduce_pipe: RTL

//   Parametrised, pipelined N-input bitwise logic reducer; successor to the 2-input registered gate.

---
 rtl/logic_reduce_pipe_if.sv | 36 +++
 rtl/logic_reduce_pipe.sv | 130 +++++++++++++
 2 files changed

// File: rtl/logic_reduce_pipe_if.sv
// ----------------------------------------------------------------------------
// logic_reduce_pipe_if
//   Handshake/data bundle for logic_reduce_pipe.
//   op        2             00=AND 01=OR 10=XOR 11=XNOR, travels with in_data
//   in_data   NUM_IN*WIDTH  word i = in_data[i*WIDTH +: WIDTH]
//   in_valid  1             transaction offered
//   in_ready  1             reducer can take the offer this cycle
//   Y         WIDTH         registered reduction result
//   out_valid 1             Y holds an unconsumed result
//   out_ready 1             downstream takes Y this cycle
//   busy      1             any transaction in flight
//   master = producer/consumer side, slave = reducer side.
// ----------------------------------------------------------------------------
interface logic_reduce_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) ();
    logic [1:0]              op;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        Y;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;

    modport master (
        output op, in_data, in_valid, out_ready,
        input  in_ready, Y, out_valid, busy
    );

    modport slave (
        input  op, in_data, in_valid, out_ready,
        output in_ready, Y, out_valid, busy
    );
endinterface

// File: rtl/logic_reduce_pipe.sv
// ----------------------------------------------------------------------------
// logic_reduce_pipe
//   Pipelined NUM_IN-input bitwise reducer (AND/OR/XOR/XNOR) built as a binary
//   tree with one register stage per level, valid/ready handshake and
//   per-stage stall (bubbles collapse while the output is blocked).
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears valid, data and op regs
//   bus      logic_reduce_pipe_if.slave (op, in_data, in_valid, in_ready,
//            Y, out_valid, out_ready, busy)
// Latency LAT = max(1, clog2(NUM_IN)) cycles, capacity LAT transactions.
// ----------------------------------------------------------------------------
module logic_reduce_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input logic                clk,
    input logic                reset_n,
    logic_reduce_pipe_if.slave bus
);
    localparam int LAT = (NUM_IN < 2) ? 1 : $clog2(NUM_IN);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XNOR = 2'b11;

    // Words held by stage k: ceil(NUM_IN / 2^(k+1)).
    function automatic int words_at(input int k);
        return (NUM_IN + (1 << (k + 1)) - 1) >> (k + 1);
    endfunction

    // Word offset of stage k inside the flat stage-data vector.
    function automatic int off_at(input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += words_at(j);
        return s;
    endfunction

    // XNOR rides the tree as XOR; the single inversion happens in the last stage.
    function automatic logic [WIDTH-1:0] op_pair(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    localparam int TOTW = off_at(LAT) * WIDTH;

    logic [TOTW-1:0]     stg_q;     // all stage data, stage 0 first
    logic [LAT-1:0]      vld_pipe;  // per-stage valid
    logic [LAT-1:0]      adv;       // stage k may load this cycle
    logic [LAT-1:0][1:0] sop;       // op presented to stage k

    // Ready ripples back from the output; an empty stage always advances.
    always_comb begin
        adv[LAT-1] = ~vld_pipe[LAT-1] | bus.out_ready;
        for (int k = LAT - 2; k >= 0; k--) adv[k] = ~vld_pipe[k] | adv[k+1];
    end

    assign sop[0] = bus.op;

    for (genvar k = 0; k < LAT; k++) begin : g_stg
        localparam int NS   = (k == 0) ? NUM_IN : words_at(k - 1);
        localparam int NW   = words_at(k);
        localparam int OFF  = off_at(k);

        logic [NS*WIDTH-1:0] src;
        logic                src_vld;
        logic [NW*WIDTH-1:0] nxt;
        logic [NW*WIDTH-1:0] data_q;
        logic                vld_q;

        if (k == 0) begin : g_src
            assign src     = bus.in_data;
            assign src_vld = bus.in_valid & adv[0];
        end else begin : g_src
            assign src     = stg_q[off_at(k-1)*WIDTH +: NS*WIDTH];
            assign src_vld = vld_pipe[k-1];
        end

        for (genvar j = 0; j < NW; j++) begin : g_w
            logic [WIDTH-1:0] w;
            // An unpaired word meets the op identity, i.e. passes through.
            if (2*j + 1 < NS) begin : g_pair
                assign w = op_pair(sop[k], src[2*j*WIDTH +: WIDTH],
                                   src[(2*j+1)*WIDTH +: WIDTH]);
            end else begin : g_pass
                assign w = src[2*j*WIDTH +: WIDTH];
            end
            if (k == LAT - 1) begin : g_last
                assign nxt[j*WIDTH +: WIDTH] = (sop[k] == OP_XNOR) ? ~w : w;
            end else begin : g_mid
                assign nxt[j*WIDTH +: WIDTH] = w;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else if (adv[k]) begin
                data_q <= nxt;
                vld_q  <= src_vld;
            end
        end

        assign stg_q[OFF*WIDTH +: NW*WIDTH] = data_q;
        assign vld_pipe[k]                  = vld_q;

        // The op register feeds the next level; the last level needs none.
        if (k < LAT - 1) begin : g_op
            logic [1:0] op_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)    op_q <= 2'b00;
                else if (adv[k]) op_q <= sop[k];
            end
            assign sop[k+1] = op_q;
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.Y         = stg_q[off_at(LAT-1)*WIDTH +: WIDTH];
    assign bus.out_valid = vld_pipe[LAT-1];
    assign bus.busy      = |vld_pipe;

endmodule
